// File: rtl/fifo_rd_serializer.sv
// Drains a standard-mode FIFO read port into a narrow valid/ready stream.
// Each wide word is emitted as IN_WIDTH/OUT_WIDTH slices, one per cycle.
module fifo_rd_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy
);

  localparam int N  = IN_WIDTH / OUT_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int NS = 2 ** CW;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [IN_WIDTH-1:0]  word0;
  logic [IN_WIDTH-1:0]  word1;
  logic [IN_WIDTH-1:0]  nxt_w0;
  logic [IN_WIDTH-1:0]  nxt_w1;
  logic [1:0]           stored;
  logic [1:0]           nxt_stored;
  logic [1:0]           occ;
  logic                 inflight;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        sel;
  logic                 hs;
  logic                 pop;
  logic [OUT_WIDTH-1:0] slices [NS];

  assign m_valid = (stored != 2'd0);
  assign hs      = m_valid && m_ready;
  assign pop     = hs && (cnt == CNT_LAST);
  assign m_last  = m_valid && (cnt == CNT_LAST);
  assign occ     = stored + {1'b0, inflight};
  assign busy    = (occ != 2'd0);

  // Lookahead on the final slice keeps one word per cycle when N=1
  assign fifo_rd_en = !rst && !fifo_empty &&
                      ((occ < 2'd2) || ((occ == 2'd2) && pop));

  for (genvar i = 0; i < NS; i++) begin : g_slice
    if (i < N) begin : g_real
      assign slices[i] = word0[i*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_pad
      assign slices[i] = '0;
    end
  end

  assign sel    = MSB_FIRST ? (CNT_LAST - cnt) : cnt;
  assign m_data = slices[sel];

  always_comb begin
    nxt_w0     = word0;
    nxt_w1     = word1;
    nxt_stored = stored;
    if (pop) begin
      nxt_w0     = word1;
      nxt_stored = stored - 2'd1;
    end
    // Returning read lands in the first free slot after any pop
    if (inflight) begin
      if (nxt_stored == 2'd0) begin
        nxt_w0 = fifo_dout;
      end else begin
        nxt_w1 = fifo_dout;
      end
      nxt_stored = nxt_stored + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word0    <= '0;
      word1    <= '0;
      stored   <= 2'd0;
      inflight <= 1'b0;
      cnt      <= '0;
    end else begin
      word0    <= nxt_w0;
      word1    <= nxt_w1;
      stored   <= nxt_stored;
      inflight <= fifo_rd_en;
      if (hs) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer: two 32->8 lanes (MSB/LSB first)
// and one 16->16 lane, each fed by a simple 1-cycle-latency FIFO model.
module tb_fifo_rd_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  rdy;
  logic [2:0]  rd_en;
  logic [2:0]  vld;
  logic [2:0]  last;
  logic [2:0]  busy;
  logic [2:0]  empty;
  logic [7:0]  d0;
  logic [7:0]  d1;
  logic [15:0] d2;
  logic [31:0] dout0;
  logic [31:0] dout1;
  logic [15:0] dout2;

  logic [31:0] mem [3][16];
  logic [3:0]  wp [3] = '{default: 4'd0};
  logic [3:0]  rp [3] = '{default: 4'd0};

  int ncmp = 0;
  int nerr = 0;

  localparam logic [7:0] E1 [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4,
                                    8'h11, 8'h22, 8'h33, 8'h44};
  localparam logic [7:0] E2 [8] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1,
                                    8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [7:0] E3 [14] = '{8'h00, 8'h00, 8'hDE, 8'hDE,
                                     8'hAD, 8'hAD, 8'hAD, 8'hBE,
                                     8'hBE, 8'hBE, 8'hEF, 8'hEF,
                                     8'hEF, 8'h01};
  localparam logic [7:0] E6 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  assign empty[0] = (rp[0] == wp[0]);
  assign empty[1] = (rp[1] == wp[1]);
  assign empty[2] = (rp[2] == wp[2]);

  always @(posedge clk) begin
    if (rd_en[0]) begin
      dout0 <= mem[0][rp[0]];
      rp[0] <= rp[0] + 4'd1;
    end
    if (rd_en[1]) begin
      dout1 <= mem[1][rp[1]];
      rp[1] <= rp[1] + 4'd1;
    end
    if (rd_en[2]) begin
      dout2 <= mem[2][rp[2]][15:0];
      rp[2] <= rp[2] + 4'd1;
    end
  end

  fifo_rd_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst[0]), .fifo_dout(dout0), .fifo_empty(empty[0]),
    .fifo_rd_en(rd_en[0]), .m_data(d0), .m_valid(vld[0]),
    .m_ready(rdy[0]), .m_last(last[0]), .busy(busy[0])
  );

  fifo_rd_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst[1]), .fifo_dout(dout1), .fifo_empty(empty[1]),
    .fifo_rd_en(rd_en[1]), .m_data(d1), .m_valid(vld[1]),
    .m_ready(rdy[1]), .m_last(last[1]), .busy(busy[1])
  );

  fifo_rd_serializer #(.IN_WIDTH(16), .OUT_WIDTH(16), .MSB_FIRST(1'b1)) u_n1 (
    .clk(clk), .rst(rst[2]), .fifo_dout(dout2), .fifo_empty(empty[2]),
    .fifo_rd_en(rd_en[2]), .m_data(d2), .m_valid(vld[2]),
    .m_ready(rdy[2]), .m_last(last[2]), .busy(busy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] w);
    mem[k][wp[k]] = w;
    wp[k] = wp[k] + 4'd1;
  endtask

  initial begin
    rst = 3'b111;
    rdy = 3'b000;
    push(0, 32'hA1B2C3D4);
    push(0, 32'h11223344);
    push(1, 32'hA1B2C3D4);
    push(1, 32'h11223344);
    for (int i = 0; i < 8; i++) push(2, i);
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rd_en", rd_en[k], 0);
      chk("rst_valid", vld[k], 0);
      chk("rst_last", last[k], 0);
      chk("rst_busy", busy[k], 0);
    end
    chk("rst_data0", d0, 0);
    chk("rst_data2", d2, 0);

    // MSB-first and LSB-first lanes run side by side
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst[1:0] = 2'b00;
        rdy[1:0] = 2'b11;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("t12_rd_en", rd_en[k], (i < 2));
        chk("t12_valid", vld[k], (i >= 2 && i <= 9));
        chk("t12_last", last[k], (i == 5 || i == 9));
        chk("t12_busy", busy[k], (i >= 1 && i <= 9));
      end
      if (i >= 2 && i <= 9) begin
        chk("t1_data", d0, E1[i-2]);
        chk("t2_data", d1, E2[i-2]);
      end
    end

    // Single-slice lane streams one word per cycle
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst[2] = 1'b0;
        rdy[2] = 1'b1;
      end
      #1;
      chk("t4_rd_en", rd_en[2], (i <= 7));
      chk("t4_rd_empty", rd_en[2] & empty[2], 0);
      chk("t4_valid", vld[2], (i >= 2 && i <= 9));
      chk("t4_busy", busy[2], (i >= 1 && i <= 9));
      if (i >= 2 && i <= 9) begin
        chk("t4_data", d2, i - 2);
        chk("t4_last", last[2], 1);
      end
    end

    // Stalled handshakes with a full buffer and more data waiting
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) begin
        push(0, 32'hDEADBEEF);
        push(0, 32'h01020304);
        push(0, 32'h05060708);
      end
      rdy[0] = (i % 3 == 0);
      #1;
      chk("t3_rd_en", rd_en[0], (i < 2 || i == 12));
      chk("t3_valid", vld[0], (i >= 2));
      chk("t3_last", last[0], (i >= 10 && i <= 12));
      chk("t3_busy", busy[0], (i >= 1));
      if (i >= 2) chk("t3_data", d0, E3[i]);
    end

    @(negedge clk);
    rst[0] = 1'b1;
    rdy[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;

    // Idle with an empty FIFO
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t5_idle_rd", rd_en[0], 0);
      chk("t5_idle_valid", vld[0], 0);
      chk("t5_idle_busy", busy[0], 0);
    end

    @(negedge clk);
    push(0, 32'hCAFEF00D);
    rdy[0] = 1'b1;
    #1;
    chk("t5_rd_t", rd_en[0], 1);
    @(negedge clk);
    #1;
    chk("t5_rd_t1", rd_en[0], 0);
    chk("t5_valid_t1", vld[0], 0);
    chk("t5_busy_t1", busy[0], 1);
    @(negedge clk);
    #1;
    chk("t5_valid_t2", vld[0], 1);
    chk("t6_data_ca", d0, 8'hCA);
    @(negedge clk);
    push(0, 32'h99887766);
    #1;
    chk("t6_data_fe", d0, 8'hFE);
    chk("t6_rd_second", rd_en[0], 1);

    // Reset lands while the second word is still in flight
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    chk("t6_rd_in_rst", rd_en[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    chk("t6_post_valid", vld[0], 0);
    chk("t6_post_busy", busy[0], 0);
    chk("t6_post_last", last[0], 0);
    chk("t6_post_data", d0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("t6_ignored_valid", vld[0], 0);
      chk("t6_ignored_busy", busy[0], 0);
    end

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) push(0, 32'h12345678);
      #1;
      chk("t6_rd_en", rd_en[0], (i == 0));
      chk("t6_valid", vld[0], (i >= 2 && i <= 5));
      chk("t6_last", last[0], (i == 5));
      chk("t6_busy", busy[0], (i >= 1 && i <= 5));
      if (i >= 2 && i <= 5) chk("t6_data", d0, E6[i-2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_rd_serializer.md
Name: fifo_rd_serializer

Overview:
Read-side companion to the team's width-converting sync FIFOs. It drains a standard-mode (non-FWFT, 1-cycle read latency) FIFO read port and presents the data as a valid/ready stream. Each IN_WIDTH word is split into IN_WIDTH/OUT_WIDTH slices. It sits between a wide FIFO and a narrow downstream consumer. It sustains one slice per cycle, with no bubbles between words.

Parameters:
IN_WIDTH, 32, FIFO word width; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 8, output slice width; N = IN_WIDTH/OUT_WIDTH (N >= 1, any integer).
MSB_FIRST, 1, 1 = most significant slice emitted first; 0 = least significant slice first.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  synchronous reset, active-high.
fifo_dout  input  IN_WIDTH  FIFO read data, valid in the cycle after fifo_rd_en.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO read strobe.
m_data  output  OUT_WIDTH  output slice.
m_valid  output  1  m_data valid.
m_ready  input  1  downstream accepts when m_valid && m_ready.
m_last  output  1  high with the final slice (index N-1) of a word.
busy  output  1  any word buffered, in flight, or partially emitted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: m_valid=0, m_last=0, m_data=0, busy=0, slice counter=0, buffer empty, in-flight flag=0. fifo_rd_en is forced 0 while rst=1.
- Reset mid-operation: all buffered words, partial words and any in-flight read are discarded. A FIFO read returning in the cycle after reset is ignored.
- Word buffer: 2 entries. occ = stored words + in-flight read (0..2).
- Read issue: fifo_rd_en = !rst && !fifo_empty && (occ_next_free). occ_next_free is true when occ < 2, or when occ == 2 and the head word completes this cycle (m_valid && m_ready && cnt == N-1).
- fifo_rd_en is combinational. It is never asserted when fifo_empty=1.
- Capture: fifo_dout is written into the buffer tail on the edge ending the cycle after fifo_rd_en.
- Latency: with an idle block, fifo_rd_en is high in cycle t and m_valid first rises in cycle t+2.
- Slice select: with slice counter cnt (width clog2(N), min 1):
  - MSB_FIRST=1: m_data = head[IN_WIDTH-1-cnt*OUT_WIDTH -: OUT_WIDTH].
  - MSB_FIRST=0: m_data = head[cnt*OUT_WIDTH +: OUT_WIDTH].
- m_valid = head entry present. m_last = m_valid && cnt == N-1.
- Handshake: while m_valid && !m_ready, m_data, m_last and m_valid hold stable. No retraction.
- On handshake with cnt < N-1: cnt increments.
- On handshake with cnt == N-1: cnt goes to 0 and the head pops. If a second word is buffered, it becomes head in the next cycle with no bubble.
- Simultaneous events: pop and capture in the same cycle are legal; occupancy is unchanged.
- N=1: every handshake pops and m_last is constant 1 while valid. The 2-entry buffer plus the lookahead in the read-issue rule sustain 1 word/cycle.
- busy = (occ != 0).
- Buffer is implemented as flops (2 x IN_WIDTH); no RAM inference.

Test Plan:
1. IN=32, OUT=8, MSB_FIRST=1; FIFO holds 0xA1B2C3D4, 0x11223344; m_ready=1 -> m_data A1,B2,C3,D4,11,22,33,44 on 8 consecutive cycles; m_last on D4 and 44; fifo_rd_en high exactly 2 cycles; busy drops after 44.
2. Same data, MSB_FIRST=0 -> D4,C3,B2,A1,44,33,22,11; m_last on A1 and 11.
3. m_ready toggled 1,0,0,1,... with 0xDEADBEEF -> each slice held stable while stalled; 4 handshakes total, DE,AD,BE,EF in order; no extra fifo_rd_en while occ=2.
4. N=1 (IN=OUT=16), 8 words 0x0000..0x0007 preloaded, m_ready=1 -> m_valid high 8 consecutive cycles, data 0..7, m_last=1 each; fifo_rd_en never asserted while fifo_empty=1.
5. FIFO empty -> fifo_rd_en=0, m_valid=0, busy=0 indefinitely. A single write makes fifo_empty=0 in cycle t -> fifo_rd_en in t, m_valid in t+2.
6. rst asserted after 2 of 4 slices of 0xCAFEF00D, with a read in flight -> cycle after rst: m_valid=0, busy=0, cnt=0; returned FIFO data is ignored; the next word starts at slice 0.
